// File: rtl/button_conditioner_if.sv
// Button bundle between board pins and game logic: raw pins in, conditioned
// level and event pulses out.
interface button_conditioner_if #(
    parameter int NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_repeat;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchroniser, debouncer and auto-repeat generator; every channel
// is fully independent and all outputs come straight from flops.
module button_conditioner #(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic                 clk,
    input  logic                 clr,
    button_conditioner_if.slave  btn
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic          meta_q, sync_q;
        logic [DW-1:0] cnt_q, cnt_d;
        logic          stable_q, stable_d;
        logic          press_q, release_q, repeat_q, repeat_d;
        logic [1:0]    state_q, state_d;
        logic [RW-1:0] rcnt_q, rcnt_d;
        logic          rise, fall;

        // NOTE: every signal gets a default at the top of always_comb so no
        // path leaves it unassigned and no latch is inferred.
        always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            // The stable level flips on a mismatched cycle once the count has
            // already reached DEBOUNCE_CYCLES; a match at any point restarts it.
            if (sync_q != stable_q) begin
                if (cnt_q == DEB_LAST) begin
                    stable_d = ~stable_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        assign rise = stable_d & ~stable_q;
        assign fall = ~stable_d & stable_q;

        always_comb begin
            state_d  = state_q;
            rcnt_d   = rcnt_q;
            repeat_d = 1'b0;
            // A falling level wins over a pending repeat in the same cycle.
            if (fall || (REPEAT_EN == 0)) begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise) begin
                            state_d = ST_DELAY;
                            rcnt_d  = '0;
                        end
                    end
                    ST_DELAY: begin
                        if (rcnt_q == DELAY_LAST) begin
                            repeat_d = 1'b1;
                            rcnt_d   = '0;
                            state_d  = ST_REPEAT;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (rcnt_q == RATE_LAST) begin
                            repeat_d = 1'b1;
                            rcnt_d   = '0;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge value of the others.
        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                meta_q    <= 1'b0;
                sync_q    <= 1'b0;
                cnt_q     <= '0;
                stable_q  <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
                state_q   <= ST_IDLE;
                rcnt_q    <= '0;
            end else begin
                meta_q    <= btn.btn_raw[i];
                sync_q    <= meta_q;
                cnt_q     <= cnt_d;
                stable_q  <= stable_d;
                press_q   <= rise;
                release_q <= fall;
                repeat_q  <= repeat_d;
                state_q   <= state_d;
                rcnt_q    <= rcnt_d;
            end
        end

        assign btn.btn_level[i]   = stable_q;
        assign btn.btn_press[i]   = press_q;
        assign btn.btn_release[i] = release_q;
        assign btn.btn_repeat[i]  = repeat_q;
    end
endmodule
